rr_grant_ctrl: RTL

//  - Round-robin arbiter controller: shares one resource among NUM_REQ requesters.
//  - A one-hot priority pointer rotates like a ring counter. A grant is held until
//    the owner releases it.
//  - Sits between requester ports and the shared resource. Drives grant, the

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_grant_ctrl_if.sv | 32 +++
 rtl/rr_priority_pick.sv | 37 +++
 rtl/rr_grant_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant controller.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after a hold limit).
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Binary index of the single set bit; zero when no bit is set.
   function automatic logic [31:0] onehot2bin(input logic [31:0] oh);
      logic [31:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = idx | 32'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Requester-side bundle for the round-robin grant controller.
// master drives requests/release, slave (the arbiter) drives the grant.
interface rr_grant_ctrl_if #(
   parameter int NUM_REQ = 4
);
   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req;
   logic               release_i;
   logic [NUM_REQ-1:0] grant;
   logic               grant_valid;
   logic [IW-1:0]      grant_idx;
   logic               timeout_err;

   modport master (
      output req,
      output release_i,
      input  grant,
      input  grant_valid,
      input  grant_idx,
      input  timeout_err
   );

   modport slave (
      input  req,
      input  release_i,
      output grant,
      output grant_valid,
      output grant_idx,
      output timeout_err
   );
endinterface

// File: rtl/rr_priority_pick.sv
// Picks the first requester starting at the one-hot pointer and walking
// downward with wrap, using a bit-reversed double-width subtract trick.
module rr_priority_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] ptr_i,
   output logic [NUM_REQ-1:0] win_o
);

   logic [NUM_REQ-1:0]   req_r;
   logic [NUM_REQ-1:0]   ptr_r;
   logic [NUM_REQ-1:0]   win_r;
   logic [2*NUM_REQ-1:0] dbl;
   logic [2*NUM_REQ-1:0] base;
   logic [2*NUM_REQ-1:0] hit;

   // Reverse so the downward walk becomes an upward search, then find the
   // lowest set bit at or above the pointer in the doubled vector.
   always_comb begin
      req_r = '0;
      ptr_r = '0;
      win_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_r[i] = req_i[NUM_REQ-1-i];
         ptr_r[i] = ptr_i[NUM_REQ-1-i];
      end
      dbl   = {req_r, req_r};
      base  = {{NUM_REQ{1'b0}}, ptr_r};
      hit   = dbl & ~(dbl - base);
      win_r = hit[NUM_REQ-1:0] | hit[2*NUM_REQ-1:NUM_REQ];
      for (int i = 0; i < NUM_REQ; i++) begin
         win_o[i] = win_r[NUM_REQ-1-i];
      end
   end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter: holds a grant until release or request drop.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT_CYCLES grant cycles.
module rr_grant_ctrl
   import arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic         clk,
   input logic         rst,
   rr_grant_ctrl_if.slave bus
);

   localparam int IW = $clog2(NUM_REQ);

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ptr_q, ptr_d;
   logic [NUM_REQ-1:0] win;
   logic               end_c;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          terr_q, terr_d;
`endif

   rr_priority_pick #(
      .NUM_REQ(NUM_REQ)
   ) u_pick (
      .req_i (bus.req),
      .ptr_i (ptr_q),
      .win_o (win)
   );

   // Owner done when it releases or withdraws its own request.
   assign end_c = bus.release_i | ~(|(bus.req & grant_q));

   // State, grant and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= NUM_REQ'(1) << (NUM_REQ-1);
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= '0;
         terr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
`endif
      end
   end

   // Next-state: latch a winner in IDLE, end the hold and rotate in GRANT.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      terr_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (|bus.req) begin
               grant_d = win;
               state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         GRANT: begin
            if (end_c) begin
               grant_d = '0;
               state_d = IDLE;
               ptr_d   = {grant_q[0], grant_q[NUM_REQ-1:1]};
`ifdef ARB_TIMEOUT_EN
            end else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
               grant_d = '0;
               state_d = IDLE;
               ptr_d   = {grant_q[0], grant_q[NUM_REQ-1:1]};
               terr_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + CW'(1);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs come straight from registers; the index is decoded from grant.
   always_comb begin
      bus.grant       = grant_q;
      bus.grant_valid = |grant_q;
      bus.grant_idx   = IW'(onehot2bin(32'(grant_q)));
`ifdef ARB_TIMEOUT_EN
      bus.timeout_err = terr_q;
`else
      bus.timeout_err = 1'b0;
`endif
   end

endmodule
